key_display_mux: RTL and testbench

Downstream stage of the keypad scanner/debouncer. Consumes a one-cycle "new key" strobe with a 4-bit hex code and keeps a two-digit history: newest digit on the right, previous digit on the left. Drives a single shared 7-segment bus time-multiplexed across two common-anode digits, with a blanking gap between digits to suppress ghosting. Replaces the per-digit decode and anode tie-off in the keypad top level.

---
 rtl/key_display_mux.sv | 183 ++++++++++++++++++
 tb/tb_key_display_mux.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/key_display_mux.sv
// -----------------------------------------------------------------------------
// key_display_mux
//
// Downstream stage of the keypad scanner/debouncer. Keeps a two-digit key
// history (newest digit on the right) and drives one shared, active-low
// 7-segment bus time-multiplexed across two common-anode digits. Both anodes
// are switched off for a short blanking gap between digits so the segment
// pattern of one digit never ghosts onto the other.
//
// Parameters:
//   REFRESH_CYCLES  clk cycles each digit is lit per SHOW phase (>= 2)
//   BLANK_CYCLES    clk cycles both anodes are off between SHOW phases (>= 1,
//                   and no larger than REFRESH_CYCLES so it fits the counter)
//
// Ports:
//   clk        in   system clock, all state on its rising edge
//   reset      in   synchronous, active-high reset
//   key_valid  in   one-cycle strobe: key_code holds a new, debounced key
//   key_code   in   [3:0] hex value of the pressed key
//   seg        out  [6:0] {g,f,e,d,c,b,a}, active-low, shared by both digits
//   anode0     out  right (newest) digit enable, active-low
//   anode1     out  left (older) digit enable, active-low
//   digit0     out  [3:0] newest stored digit
//   digit1     out  [3:0] older stored digit
//   dbg_state  out  [1:0] current display-scan state (SHOW0/BLANK0/SHOW1/BLANK1)
//
// Handshake: key_valid is a pure strobe with no back-pressure. Every cycle in
// which key_valid=1 (and reset=0) shifts the history by one position on the
// next rising edge; consecutive strobes shift once per cycle.
// -----------------------------------------------------------------------------
module key_display_mux #(
  parameter int REFRESH_CYCLES = 48000,
  parameter int BLANK_CYCLES   = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [6:0] seg,
  output logic       anode0,
  output logic       anode1,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [1:0] dbg_state
);

  localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  // Terminal counts: each phase runs counter values 0 .. N-1.
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {
    SHOW0  = 2'd0,
    BLANK0 = 2'd1,
    SHOW1  = 2'd2,
    BLANK1 = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [3:0]    digit0_q, digit0_d;
  logic [3:0]    digit1_q, digit1_d;
  logic          valid0_q, valid0_d;
  logic          valid1_q, valid1_d;
  logic          phase_done;

  // Hex to active-low 7-segment pattern, bit 6 = g ... bit 0 = a.
  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'h0:    pat = 7'h40;
      4'h1:    pat = 7'h79;
      4'h2:    pat = 7'h24;
      4'h3:    pat = 7'h30;
      4'h4:    pat = 7'h19;
      4'h5:    pat = 7'h12;
      4'h6:    pat = 7'h02;
      4'h7:    pat = 7'h78;
      4'h8:    pat = 7'h00;
      4'h9:    pat = 7'h10;
      4'hA:    pat = 7'h08;
      4'hB:    pat = 7'h03;
      4'hC:    pat = 7'h46;
      4'hD:    pat = 7'h21;
      4'hE:    pat = 7'h06;
      default: pat = 7'h0E;
    endcase
    return pat;
  endfunction

  // ---------------------------------------------------------------------------
  // State, counter and history registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= BLANK1;
      cnt_q    <= '0;
      digit0_q <= 4'h0;
      digit1_q <= 4'h0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      digit0_q <= digit0_d;
      digit1_q <= digit1_d;
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: scan sequencer and key history shift
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    phase_done = 1'b0;

    case (state_q)
      SHOW0, SHOW1: phase_done = (cnt_q == SHOW_LAST);
      default:      phase_done = (cnt_q == BLANK_LAST);
    endcase

    if (phase_done) begin
      cnt_d = '0;
      case (state_q)
        SHOW0:   state_d = BLANK0;
        BLANK0:  state_d = SHOW1;
        SHOW1:   state_d = BLANK1;
        default: state_d = SHOW0;
      endcase
    end
  end

  // The history shift is independent of the scan sequence, so a key arriving
  // mid-SHOW only changes what is lit, never the timing.
  always_comb begin
    digit0_d = digit0_q;
    digit1_d = digit1_q;
    valid0_d = valid0_q;
    valid1_d = valid1_q;
    if (key_valid) begin
      digit1_d = digit0_q;
      valid1_d = valid0_q;
      digit0_d = key_code;
      valid0_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: combinational from registered state. Positions never written
  // since reset stay dark rather than showing a stale '0'.
  // ---------------------------------------------------------------------------
  always_comb begin
    anode0 = 1'b1;
    anode1 = 1'b1;
    seg    = SEG_OFF;
    case (state_q)
      SHOW0: begin
        anode0 = 1'b0;
        seg    = valid0_q ? decode(digit0_q) : SEG_OFF;
      end
      SHOW1: begin
        anode1 = 1'b0;
        seg    = valid1_q ? decode(digit1_q) : SEG_OFF;
      end
      default: begin
        anode0 = 1'b1;
        anode1 = 1'b1;
        seg    = SEG_OFF;
      end
    endcase
  end

  assign digit0    = digit0_q;
  assign digit1    = digit1_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_key_display_mux.sv
// -----------------------------------------------------------------------------
// tb_key_display_mux
//
// Directed bench for key_display_mux with REFRESH_CYCLES=8, BLANK_CYCLES=2.
// One scan period is 20 cycles: 2 blank, 8 SHOW0, 2 blank, 8 SHOW1.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_key_display_mux;

  localparam int REFRESH = 8;
  localparam int BLANK   = 2;
  localparam int PERIOD  = 2 * (REFRESH + BLANK);

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic [6:0] seg;
  logic       anode0;
  logic       anode1;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  key_display_mux #(
    .REFRESH_CYCLES(REFRESH),
    .BLANK_CYCLES  (BLANK)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .key_valid(key_valid),
    .key_code (key_code),
    .seg      (seg),
    .anode0   (anode0),
    .anode1   (anode1),
    .digit0   (digit0),
    .digit1   (digit1),
    .dbg_state(dbg_state)
  );

  // Active-low segment patterns for 0..F, bit 6 = g.
  logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------------
  // Driver / checker tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic a0, input logic a1,
                           input logic [6:0] s);
    chk({tag, "_anode0"}, {7'd0, anode0}, {7'd0, a0});
    chk({tag, "_anode1"}, {7'd0, anode1}, {7'd0, a1});
    chk({tag, "_seg"},    {1'b0, seg},    {1'b0, s});
  endtask

  // Check the outputs for n consecutive cycles, advancing one clock after each.
  task automatic run_phase(input string tag, input int n, input logic a0,
                           input logic a1, input logic [6:0] s);
    for (int i = 0; i < n; i++) begin
      check_out(tag, a0, a1, s);
      step();
    end
  endtask

  task automatic strobe_step(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    step();
    key_valid = 1'b0;
  endtask

  // Scoreboard model for the random section.
  logic [3:0] m_d0, m_d1;
  logic       m_v0, m_v1;
  int         m_pos;
  logic       e_a0, e_a1;
  logic [6:0] e_seg;

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset     = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    step();
    step();

    // Reset state
    check_out("reset", 1'b1, 1'b1, 7'h7F);
    chk("reset_digit0", {4'd0, digit0}, 8'h00);
    chk("reset_digit1", {4'd0, digit1}, 8'h00);
    chk("reset_state",  {6'd0, dbg_state}, 8'h03);
    reset = 1'b0;

    // Idle scan with no keys: 20-cycle period, all digits dark.
    run_phase("idle_blank1", BLANK,   1'b1, 1'b1, 7'h7F);
    run_phase("idle_show0",  REFRESH, 1'b0, 1'b1, 7'h7F);
    run_phase("idle_blank0", BLANK,   1'b1, 1'b1, 7'h7F);
    run_phase("idle_show1",  REFRESH, 1'b1, 0,    7'h7F);
    // Now at the start of BLANK1.

    // Single strobe, code 5, in the first BLANK1 cycle.
    strobe_step(4'h5);
    chk("k5_digit0", {4'd0, digit0}, 8'h05);
    run_phase("k5_blank1", 1,       1'b1, 1'b1, 7'h7F);
    run_phase("k5_show0",  REFRESH, 1'b0, 1'b1, 7'h12);
    run_phase("k5_blank0", BLANK,   1'b1, 1'b1, 7'h7F);
    run_phase("k5_show1",  REFRESH, 1'b1, 1'b0, 7'h7F);

    // Strobes A then F across the two BLANK1 cycles.
    strobe_step(4'hA);
    strobe_step(4'hF);
    chk("af_digit1", {4'd0, digit1}, 8'h0A);
    chk("af_digit0", {4'd0, digit0}, 8'h0F);
    run_phase("af_show0",  REFRESH, 1'b0, 1'b1, 7'h0E);
    run_phase("af_blank0", BLANK,   1'b1, 1'b1, 7'h7F);
    run_phase("af_show1",  REFRESH, 1'b1, 1'b0, 7'h08);

    // Back-to-back strobes 1,2,3; the third lands in the first SHOW0 cycle.
    strobe_step(4'h1);
    strobe_step(4'h2);
    check_out("b2b_show0_first", 1'b0, 1'b1, 7'h24);
    strobe_step(4'h3);
    chk("b2b_digit1", {4'd0, digit1}, 8'h02);
    chk("b2b_digit0", {4'd0, digit0}, 8'h03);
    run_phase("b2b_show0",  REFRESH - 1, 1'b0, 1'b1, 7'h30);
    run_phase("b2b_blank0", BLANK,       1'b1, 1'b1, 7'h7F);
    run_phase("b2b_show1",  REFRESH,     1'b1, 1'b0, 7'h24);

    // Strobe code 8 in cycle 4 of SHOW0; seg changes next cycle, phase length unchanged.
    run_phase("mid_blank1", BLANK, 1'b1, 1'b1, 7'h7F);
    run_phase("mid_show0_pre", 3, 1'b0, 1'b1, 7'h30);
    check_out("mid_show0_strobe", 1'b0, 1'b1, 7'h30);
    strobe_step(4'h8);
    run_phase("mid_show0_post", REFRESH - 4, 1'b0, 1'b1, 7'h00);
    run_phase("mid_blank0", BLANK, 1'b1, 1'b1, 7'h7F);
    run_phase("mid_show1",  4,     1'b1, 1'b0, 7'h30);

    // Reset in the middle of SHOW1, with a strobe in the same cycle (dropped).
    reset     = 1'b1;
    key_valid = 1'b1;
    key_code  = 4'h7;
    step();
    reset     = 1'b0;
    key_valid = 1'b0;
    check_out("rst_mid", 1'b1, 1'b1, 7'h7F);
    chk("rst_mid_digit0", {4'd0, digit0}, 8'h00);
    chk("rst_mid_digit1", {4'd0, digit1}, 8'h00);
    chk("rst_mid_state",  {6'd0, dbg_state}, 8'h03);
    // Cleared history must stay dark even though digits read 0.
    run_phase("rst_blank1", BLANK,   1'b1, 1'b1, 7'h7F);
    run_phase("rst_show0",  REFRESH, 1'b0, 1'b1, 7'h7F);
    run_phase("rst_blank0", BLANK,   1'b1, 1'b1, 7'h7F);
    run_phase("rst_show1",  REFRESH, 1'b1, 1'b0, 7'h7F);

    // Random strobes against a scoreboard model, 1000 cycles after a fresh reset.
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_d0  = 4'h0;
    m_d1  = 4'h0;
    m_v0  = 1'b0;
    m_v1  = 1'b0;
    m_pos = 0;
    for (int i = 0; i < 1000; i++) begin
      e_a0  = 1'b1;
      e_a1  = 1'b1;
      e_seg = 7'h7F;
      if (m_pos >= BLANK && m_pos < BLANK + REFRESH) begin
        e_a0  = 1'b0;
        e_seg = m_v0 ? dec[m_d0] : 7'h7F;
      end else if (m_pos >= 2 * BLANK + REFRESH) begin
        e_a1  = 1'b0;
        e_seg = m_v1 ? dec[m_d1] : 7'h7F;
      end
      check_out("rand", e_a0, e_a1, e_seg);
      chk("rand_digit0", {4'd0, digit0}, {4'd0, m_d0});
      chk("rand_anodes_exclusive", {7'd0, anode0 | anode1}, 8'h01);

      key_valid = ($urandom_range(0, 3) == 0);
      key_code  = 4'($urandom_range(0, 15));
      step();
      if (key_valid) begin
        m_d1 = m_d0;
        m_v1 = m_v0;
        m_d0 = key_code;
        m_v0 = 1'b1;
      end
      m_pos = (m_pos + 1) % PERIOD;
    end
    key_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
